// File: rtl/y86_dmem.sv
// Y86 data-memory responder: byte array with combinational little-endian word reads,
// single-edge CPU writes, a byte load port, a sticky protocol-error flag and access counters.
module y86_dmem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [7:0]        ld_byte_i,
  output logic              err_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int NBYTES = DATA_W / 8;

  logic [7:0]        memArr   [DEPTH];
  logic [ADDR_W-1:0] byteAddr [NBYTES];
  logic [DATA_W-1:0] rdWord;
  logic              wrCommit;
  logic              protoErr;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Byte lanes wrap modulo DEPTH because DEPTH == 2**ADDR_W.
  for (genvar k = 0; k < NBYTES; k++) begin : gLane
    assign byteAddr[k]       = mem_addr_i + ADDR_W'(k);
    assign rdWord[8*k +: 8]  = memArr[byteAddr[k]];
  end

  // A read always wins over a write in the same cycle, so the read sees pre-edge contents.
  assign wrCommit   = mem_write_i && !mem_read_i;
  assign protoErr   = (mem_read_i && mem_write_i) || (ld_en_i && wrCommit);
  assign mem_data_o = (rst && mem_read_i) ? rdWord : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) memArr[i] <= 8'h00;
      err_o    <= 1'b0;
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (wrCommit) begin
        for (int k = 0; k < NBYTES; k++) memArr[byteAddr[k]] <= mem_data_i[8*k +: 8];
      end else if (ld_en_i) begin
        memArr[ld_addr_i] <= ld_byte_i;
      end
      if (protoErr)   err_o    <= 1'b1;
      if (mem_read_i) rd_cnt_o <= satInc(rd_cnt_o);
      if (wrCommit)   wr_cnt_o <= satInc(wr_cnt_o);
    end
  end

endmodule
